// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing helpers for the async FIFO.
// Gray encode, pointer width helper and output-slot state type.
package cdc_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int PTR_W_MAX       = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_max_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_VALID = 1'b1
    } slot_state_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Narrower pointers zero-extend into this, so the low bits stay exact.
    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_gray2bin.sv
// Gray to binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray_i,
    output logic [DATA_WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[DATA_WIDTH-1:i];
    end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Async FIFO read-domain controller.
// Owns the read pointer, syncs the write pointer, runs a FWFT output slot.
module async_fifo_rd_ctrl
    import cdc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH:0]   wptr_gray_i,
    output logic [ADDR_WIDTH:0]   rptr_gray_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   rd_level_o
);

    localparam int PW     = ptr_width(ADDR_WIDTH);
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ?
                            SYNC_STAGES_MIN : SYNC_STAGES;

    typedef logic [ptr_width(ADDR_WIDTH)-1:0] ptr_t;

    ptr_t        sync_q [STAGES];
    ptr_t        wsync_gray;
    ptr_t        wsync_bin;
    ptr_t        rptr_bin;
    ptr_t        rptr_bin_next;
    ptr_t        rptr_gray_q;
    ptr_t        rptr_gray_d;
    ptr_max_t    rptr_gray_wide;
    logic [PTR_W_MAX-PW-1:0] unused_gray_hi;
    slot_state_e state_q;
    slot_state_e state_d;
    logic        ram_empty;
    logic        slot_valid;
    logic        issue;

    // Flop chain bringing the write-domain Gray pointer into this clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wptr_gray_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wsync_gray = sync_q[STAGES-1];

    gray2bin #(
        .DATA_WIDTH(PW)
    ) u_wsync_g2b (
        .gray_i(wsync_gray),
        .bin_o (wsync_bin)
    );

    // Gray compare over the full width, wrap bit included.
    assign ram_empty  = (rptr_gray_q == wsync_gray);
    assign slot_valid = (state_q == SLOT_VALID);
    assign issue      = !ram_empty && (!slot_valid || rd_ready_i);

    assign rptr_bin_next  = rptr_bin + {{(PW-1){1'b0}}, issue};
    assign rptr_gray_wide = bin2gray(ptr_max_t'(rptr_bin_next));
    assign rptr_gray_d    = rptr_gray_wide[PW-1:0];
    assign unused_gray_hi = rptr_gray_wide[PTR_W_MAX-1:PW];

    // Binary and Gray read pointers advance together; Gray is registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_bin    <= '0;
            rptr_gray_q <= '0;
        end else begin
            rptr_bin    <= rptr_bin_next;
            rptr_gray_q <= rptr_gray_d;
        end
    end

    // Output slot state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= SLOT_EMPTY;
        else         state_q <= state_d;
    end

    // Slot fills on issue, refills without a bubble, drains on ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (issue) state_d = SLOT_VALID;
            SLOT_VALID: if (rd_ready_i && !issue) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    assign rptr_gray_o   = rptr_gray_q;
    assign mem_rd_en_o   = issue;
    assign mem_rd_addr_o = rptr_bin[ADDR_WIDTH-1:0];
    assign rd_valid_o    = slot_valid;
    assign rd_data_o     = mem_rdata_i;
    assign empty_o       = ram_empty && !slot_valid;
    assign rd_level_o    = wsync_bin - rptr_bin + {{(PW-1){1'b0}}, slot_valid};

    a_rptr_gray_step: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        $countones(rptr_gray_q ^ $past(rptr_gray_q)) <= 1
    );

    a_no_issue_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ram_empty |-> !issue
    );

    a_data_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (slot_valid && !rd_ready_i) |=> $stable(rd_data_o)
    );

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for the async FIFO read controller.
// Queue-based reference model, behavioural sync-read RAM.
module tb_async_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [3:0] wptr_gray_i;
    logic [3:0] rptr_gray_o;
    logic       mem_rd_en_o;
    logic [2:0] mem_rd_addr_o;
    logic [7:0] mem_rdata_i;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic [7:0] rd_data_o;
    logic       empty_o;
    logic [3:0] rd_level_o;

    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    logic [2:0] addr_log [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pop = 0;
    int         wbin  = 0;

    always #5 clk = ~clk;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH (3),
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .wptr_gray_i  (wptr_gray_i),
        .rptr_gray_o  (rptr_gray_o),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .empty_o      (empty_o),
        .rd_level_o   (rd_level_o)
    );

    // Sync-read RAM: data appears the cycle after the strobe and is held.
    always @(posedge clk) begin
        if (mem_rd_en_o === 1'b1) mem_rdata_i <= mem[mem_rd_addr_o];
    end

    // Consumer side: every accepted word must be the oldest one written.
    always @(negedge clk) begin
        if (rst_ni === 1'b1 && rd_valid_o === 1'b1 && rd_ready_i === 1'b1) begin
            n_cmp++;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_order: got %0h, expected no word", rd_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data_o !== e) begin
                    n_err++;
                    $display("FAIL pop_order: got %0h, expected %0h", rd_data_o, e);
                end
            end
        end
        if (rst_ni === 1'b1 && mem_rd_en_o === 1'b1) addr_log.push_back(mem_rd_addr_o);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    task automatic push_word(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        wbin++;
        wptr_gray_i = to_gray(wbin);
        exp_q.push_back(d);
    endtask

    task automatic do_reset;
        rst_ni      = 1'b0;
        rd_ready_i  = 1'b0;
        wptr_gray_i = '0;
        wbin        = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_drained(input string name);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && empty_o === 1'b1) && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 60) begin
            n_err++;
            $display("FAIL %s_drain: got %0d words left, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_ni      = 1'b0;
        rd_ready_i  = 1'b0;
        wptr_gray_i = '0;
        @(negedge clk);
        n_cmp++;
        if (empty_o !== 1'b1) begin
            n_err++; $display("FAIL rst_empty: got %b, expected 1", empty_o);
        end
        n_cmp++;
        if (rd_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_valid: got %b, expected 0", rd_valid_o);
        end
        n_cmp++;
        if (rptr_gray_o !== 4'b0000) begin
            n_err++; $display("FAIL rst_rptr: got %b, expected 0000", rptr_gray_o);
        end
        n_cmp++;
        if (mem_rd_en_o !== 1'b0) begin
            n_err++; $display("FAIL rst_rd_en: got %b, expected 0", mem_rd_en_o);
        end
        n_cmp++;
        if (rd_level_o !== 4'd0) begin
            n_err++; $display("FAIL rst_level: got %0d, expected 0", rd_level_o);
        end
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_first_word;
        @(posedge clk);
        #1 push_word(8'hA5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_rd_en_o !== (c == 2)) begin
                n_err++;
                $display("FAIL lat_rd_en c%0d: got %b, expected %b", c, mem_rd_en_o, c == 2);
            end
            if (c == 2) begin
                n_cmp++;
                if (mem_rd_addr_o !== 3'd0) begin
                    n_err++; $display("FAIL lat_addr: got %0d, expected 0", mem_rd_addr_o);
                end
            end
            n_cmp++;
            if (rd_valid_o !== (c == 3)) begin
                n_err++;
                $display("FAIL lat_valid c%0d: got %b, expected %b", c, rd_valid_o, c == 3);
            end
        end
        n_cmp++;
        if (rd_level_o !== 4'd1) begin
            n_err++; $display("FAIL lat_level: got %0d, expected 1", rd_level_o);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) begin
                n_err++;
                $display("FAIL hold_%0d: got v=%b d=%0h, expected v=1 d=a5", i, rd_valid_o, rd_data_o);
            end
        end
        @(posedge clk);
        #1 rd_ready_i = 1'b1;
        @(posedge clk);
        #1 rd_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (empty_o !== 1'b1 || rd_level_o !== 4'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL first_drain: got e=%b l=%0d q=%0d, expected e=1 l=0 q=0",
                     empty_o, rd_level_o, exp_q.size());
        end
    endtask

    task automatic test_full_burst;
        int t;
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'($urandom));
        rd_ready_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (mem_rd_en_o !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 10) begin
            n_err++; $display("FAIL burst_start: got no read, expected read within 10");
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (mem_rd_en_o !== 1'b1 || mem_rd_addr_o !== 3'(i)) begin
                n_err++;
                $display("FAIL burst_%0d: got en=%b a=%0d, expected en=1 a=%0d",
                         i, mem_rd_en_o, mem_rd_addr_o, i);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (mem_rd_en_o !== 1'b0) begin
            n_err++; $display("FAIL burst_end: got en=%b, expected 0", mem_rd_en_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (empty_o !== 1'b1 || rptr_gray_o !== to_gray(wbin) || rd_level_o !== 4'd0) begin
            n_err++;
            $display("FAIL burst_final: got e=%b g=%b l=%0d, expected e=1 g=%b l=0",
                     empty_o, rptr_gray_o, rd_level_o, to_gray(wbin));
        end
    endtask

    task automatic test_wrap;
        logic [2:0] want [4];
        want = '{3'd6, 3'd7, 3'd0, 3'd1};
        @(posedge clk);
        #1 rd_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'($urandom));
        wait_drained("wrap_pre");
        n_cmp++;
        if (rptr_gray_o !== to_gray(14)) begin
            n_err++; $display("FAIL wrap_at14: got %b, expected %b", rptr_gray_o, to_gray(14));
        end
        @(posedge clk);
        #1 rd_ready_i = 1'b0;
        addr_log.delete();
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rd_level_o !== 4'd4 || rd_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_level: got l=%0d v=%b, expected l=4 v=1", rd_level_o, rd_valid_o);
        end
        @(posedge clk);
        #1 rd_ready_i = 1'b1;
        wait_drained("wrap");
        n_cmp++;
        if (addr_log.size() != 4) begin
            n_err++; $display("FAIL wrap_addr_n: got %0d, expected 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (addr_log[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL wrap_addr_%0d: got %0d, expected %0d", i, addr_log[i], want[i]);
                end
            end
        end
        n_cmp++;
        if (rptr_gray_o !== 4'b0011 || rd_level_o !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_final: got g=%b l=%0d, expected g=0011 l=0", rptr_gray_o, rd_level_o);
        end
    endtask

    task automatic test_backpressure;
        int p0;
        @(posedge clk);
        #1 rd_ready_i = 1'b0;
        p0 = n_pop;
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 rd_ready_i = ~rd_ready_i;
            if (n_pop - p0 >= 5) break;
        end
        rd_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_pop - p0 != 5 || exp_q.size() != 0 || empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_count: got pops=%0d q=%0d e=%b, expected pops=5 q=0 e=1",
                     n_pop - p0, exp_q.size(), empty_o);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (rd_level_o > exp_q.size()) begin
                n_err++;
                $display("FAIL rnd_level_%0d: got %0d, expected <= %0d", i, rd_level_o, exp_q.size());
            end
            rd_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && exp_q.size() < 8) push_word(8'($urandom));
        end
        rd_ready_i = 1'b1;
        wait_drained("rnd");
        n_cmp++;
        if (rd_level_o !== 4'd0 || rptr_gray_o !== to_gray(wbin)) begin
            n_err++;
            $display("FAIL rnd_final: got l=%0d g=%b, expected l=0 g=%b",
                     rd_level_o, rptr_gray_o, to_gray(wbin));
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rd_valid_o !== 1'b1 || rd_level_o !== 4'd5) begin
            n_err++;
            $display("FAIL mid_pre: got v=%b l=%0d, expected v=1 l=5", rd_valid_o, rd_level_o);
        end
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (rd_valid_o !== 1'b0 || empty_o !== 1'b1 || rd_level_o !== 4'd0 ||
            mem_rd_en_o !== 1'b0 || rptr_gray_o !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b e=%b l=%0d en=%b g=%b, expected v=0 e=1 l=0 en=0 g=0000",
                     rd_valid_o, empty_o, rd_level_o, mem_rd_en_o, rptr_gray_o);
        end
        exp_q.delete();
        wbin        = 0;
        wptr_gray_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
